// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Types and constants shared by the fetch and control blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int OPCODE_W = 7;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'h6F;
    localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'h67;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'h63;

    typedef enum logic [2:0] {
        FETCH_REQ   = 3'd0,
        FETCH_WAIT  = 3'd1,
        FETCH_HOLD  = 3'd2,
        FETCH_FLUSH = 3'd3
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        FETCH_ERR   = 3'd4
`endif
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : PC owner and single-outstanding instruction fetch with a
//               registered valid/ready output stage toward decode.
//               FETCH_ALIGN_CHECK_EN enables the misaligned-redirect ERR state.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic                          clk_w_i,
    input  logic                          rst_w_i_l,
    output logic                          imem_req_w_o_h,
    output logic [31:0]                   imem_addr_w_o,
    input  logic                          imem_gnt_w_i_h,
    input  logic                          imem_rvalid_w_i_h,
    input  logic [31:0]                   imem_rdata_w_i,
    input  logic                          redirect_w_i_h,
    input  logic [31:0]                   redirect_pc_w_i,
    output logic                          instr_valid_w_o_h,
    input  logic                          instr_ready_w_i_h,
    output logic [31:0]                   instr_w_o,
    output logic [cpu_pkg::OPCODE_W-1:0]  opcode_w_o,
    output logic [31:0]                   pc_w_o,
    output logic                          misalign_w_o_h
);
    import cpu_pkg::*;

    fetch_state_e state_q;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  pc_q;
    logic         instr_valid_q;

    logic [31:0]  redirect_tgt_w;
    logic         busy_after_redirect_w;
    fetch_state_e redirect_idle_w;
    fetch_state_e flush_done_w;

    // A read is still owed by memory after this cycle, so a redirect must flush it.
    assign busy_after_redirect_w = ((state_q == FETCH_REQ) && imem_gnt_w_i_h) ||
                                   (((state_q == FETCH_WAIT) || (state_q == FETCH_FLUSH)) &&
                                    !imem_rvalid_w_i_h);

`ifdef FETCH_ALIGN_CHECK_EN
    logic mis_pend_q;

    assign redirect_tgt_w  = redirect_pc_w_i;
    assign redirect_idle_w = (|redirect_pc_w_i[1:0]) ? FETCH_ERR : FETCH_REQ;
    assign flush_done_w    = mis_pend_q ? FETCH_ERR : FETCH_REQ;
    assign misalign_w_o_h  = (state_q == FETCH_ERR);
`else
    logic unused_redirect_lsb_w;

    assign unused_redirect_lsb_w = ^redirect_pc_w_i[1:0];
    assign redirect_tgt_w        = {redirect_pc_w_i[31:2], 2'b00};
    assign redirect_idle_w       = FETCH_REQ;
    assign flush_done_w          = FETCH_REQ;
    assign misalign_w_o_h        = 1'b0;
`endif

    always_ff @(posedge clk_w_i) begin
        if (!rst_w_i_l) begin
            state_q       <= FETCH_REQ;
            fetch_pc_q    <= RESET_PC;
            instr_q       <= NOP_INSTR;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            mis_pend_q    <= 1'b0;
`endif
        end else if (redirect_w_i_h) begin
            fetch_pc_q    <= redirect_tgt_w;
            instr_valid_q <= 1'b0;
            state_q       <= busy_after_redirect_w ? FETCH_FLUSH : redirect_idle_w;
`ifdef FETCH_ALIGN_CHECK_EN
            mis_pend_q    <= |redirect_pc_w_i[1:0];
`endif
        end else begin
            case (state_q)
                FETCH_REQ: begin
                    if (imem_gnt_w_i_h) state_q <= FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    if (imem_rvalid_w_i_h) begin
                        instr_q       <= imem_rdata_w_i;
                        pc_q          <= fetch_pc_q;
                        instr_valid_q <= 1'b1;
                        fetch_pc_q    <= fetch_pc_q + 32'd4;
                        state_q       <= FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (instr_ready_w_i_h) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= FETCH_REQ;
                    end
                end
                FETCH_FLUSH: begin
                    if (imem_rvalid_w_i_h) state_q <= flush_done_w;
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign imem_req_w_o_h    = rst_w_i_l && (state_q == FETCH_REQ);
    assign imem_addr_w_o     = fetch_pc_q;
    assign instr_valid_w_o_h = instr_valid_q;
    assign instr_w_o         = instr_q;
    assign opcode_w_o        = instr_q[OPCODE_W-1:0];
    assign pc_w_o            = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch (vector table, scoreboard
//               of delivered instructions, hand sequences for corner cases).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] D0  = 32'h00A0_0093;
    localparam logic [31:0] D1  = 32'h0010_8113;
    localparam logic [31:0] D2  = 32'h0000_006F;
    localparam logic [31:0] D3  = 32'hFE00_0CE3;
    localparam logic [31:0] D4  = 32'h0040_0067;
    localparam logic [31:0] D5  = 32'h1234_5037;
    localparam logic [31:0] D6  = 32'h0BAD_0013;
    localparam logic [31:0] D7  = 32'h0080_0A33;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;
    localparam logic [31:0] Z   = 32'h0;
    localparam logic        H   = 1'b1;
    localparam logic        L   = 1'b0;

    logic clk_w = 1'b0;
    always #5 clk_w = ~clk_w;

    logic        rst_l, gnt, rvalid, redir, ready;
    logic [31:0] rdata, rpc;
    logic        req, valid, mis;
    logic [31:0] addr, instr, pc;
    logic [6:0]  opcode;

    logic        rst2_l, gnt2, rvalid2, ready2;
    logic [31:0] rdata2;
    logic        req2, valid2, mis2;
    logic [31:0] addr2, instr2, pc2;
    logic [6:0]  opcode2;

    instr_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut (
        .clk_w_i(clk_w), .rst_w_i_l(rst_l),
        .imem_req_w_o_h(req), .imem_addr_w_o(addr),
        .imem_gnt_w_i_h(gnt), .imem_rvalid_w_i_h(rvalid), .imem_rdata_w_i(rdata),
        .redirect_w_i_h(redir), .redirect_pc_w_i(rpc),
        .instr_valid_w_o_h(valid), .instr_ready_w_i_h(ready),
        .instr_w_o(instr), .opcode_w_o(opcode), .pc_w_o(pc), .misalign_w_o_h(mis)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk_w_i(clk_w), .rst_w_i_l(rst2_l),
        .imem_req_w_o_h(req2), .imem_addr_w_o(addr2),
        .imem_gnt_w_i_h(gnt2), .imem_rvalid_w_i_h(rvalid2), .imem_rdata_w_i(rdata2),
        .redirect_w_i_h(1'b0), .redirect_pc_w_i(32'h0),
        .instr_valid_w_o_h(valid2), .instr_ready_w_i_h(ready2),
        .instr_w_o(instr2), .opcode_w_o(opcode2), .pc_w_o(pc2), .misalign_w_o_h(mis2)
    );

    typedef struct {
        logic        gnt, rv, dl;
        logic [31:0] rdata;
        logic        rdy, redir;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc, einstr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] granted_addr = 32'h0;

    function automatic vec_t mk(input logic g, input logic rv, input logic dl,
                                input logic [31:0] rd, input logic rdy, input logic rdr,
                                input logic [31:0] rp, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.gnt = g; v.rv = rv; v.dl = dl; v.rdata = rd; v.rdy = rdy; v.redir = rdr;
        v.rpc = rp; v.ereq = er; v.eaddr = ea; v.evalid = ev; v.epc = ep; v.einstr = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Every handshake with decode must match the oldest expected delivery.
    task automatic sb_monitor();
        if (valid === 1'b1 && ready === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got pc %h instr %h, expected no delivery", pc, instr);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("sb_pc", pc, e.pc);
                chk("sb_instr", instr, e.instr);
            end
        end
    endtask

    task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic rdr, input logic [31:0] rp);
        @(negedge clk_w);
        gnt = g; rvalid = rv; rdata = rd; ready = rdy; redir = rdr; rpc = rp;
        #1;
        sb_monitor();
    endtask

    task automatic cyc2(input logic g, input logic rv, input logic [31:0] rd, input logic rdy);
        @(negedge clk_w);
        rst2_l = 1'b1; gnt2 = g; rvalid2 = rv; rdata2 = rd; ready2 = rdy;
        #1;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk_w);
        rst_l = 1'b1;
        gnt = v.gnt; rvalid = v.rv; rdata = v.rdata; ready = v.rdy; redir = v.redir; rpc = v.rpc;
        if (v.gnt) granted_addr = v.eaddr;
        if (v.rv && v.dl) sbq.push_back('{granted_addr, v.rdata});
        #1;
        chk1($sformatf("v%0d req", idx), req, v.ereq);
        if (v.ereq) chk($sformatf("v%0d addr", idx), addr, v.eaddr);
        chk1($sformatf("v%0d valid", idx), valid, v.evalid);
        if (v.evalid) begin
            chk($sformatf("v%0d pc", idx), pc, v.epc);
            chk($sformatf("v%0d instr", idx), instr, v.einstr);
            chk($sformatf("v%0d opcode", idx), {25'b0, opcode}, {25'b0, v.einstr[6:0]});
        end
        chk1($sformatf("v%0d misalign", idx), mis, 1'b0);
        sb_monitor();
    endtask

    initial begin
        rst_l = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = Z; redir = 1'b0; rpc = Z; ready = 1'b0;
        rst2_l = 1'b0; gnt2 = 1'b0; rvalid2 = 1'b0; rdata2 = Z; ready2 = 1'b0;
        repeat (3) @(posedge clk_w);
        @(negedge clk_w);
        #1;
        chk1("rst req", req, 1'b0);
        chk("rst addr", addr, 32'h0);
        chk1("rst valid", valid, 1'b0);
        chk("rst instr", instr, NOP);
        chk("rst opcode", {25'b0, opcode}, 32'h13);
        chk("rst pc", pc, 32'h0);
        chk1("rst misalign", mis, 1'b0);
        chk("rst wrap addr", addr2, 32'hFFFF_FFFC);

        //             gnt rv dl rdata rdy rdr rpc           req addr          vld pc            instr
        vecs.push_back(mk(H, L, L, Z,   H, L, Z,            H, 32'h0,         L, Z,            Z));
        vecs.push_back(mk(L, H, H, D0,  H, L, Z,            L, Z,             L, Z,            Z));
        vecs.push_back(mk(L, L, L, Z,   H, L, Z,            L, Z,             H, 32'h0,        D0));
        vecs.push_back(mk(H, L, L, Z,   H, L, Z,            H, 32'h4,         L, Z,            Z));
        vecs.push_back(mk(L, H, H, D1,  H, L, Z,            L, Z,             L, Z,            Z));
        vecs.push_back(mk(L, L, L, Z,   H, L, Z,            L, Z,             H, 32'h4,        D1));
        vecs.push_back(mk(H, L, L, Z,   H, L, Z,            H, 32'h8,         L, Z,            Z));
        vecs.push_back(mk(L, H, H, D2,  H, L, Z,            L, Z,             L, Z,            Z));
        vecs.push_back(mk(L, L, L, Z,   H, L, Z,            L, Z,             H, 32'h8,        D2));
        vecs.push_back(mk(H, L, L, Z,   H, L, Z,            H, 32'hC,         L, Z,            Z));
        vecs.push_back(mk(L, H, H, D3,  H, L, Z,            L, Z,             L, Z,            Z));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(H, L, L, Z, L, L, Z,          L, Z,             H, 32'hC,        D3));
        vecs.push_back(mk(L, L, L, Z,   H, L, Z,            L, Z,             H, 32'hC,        D3));
        vecs.push_back(mk(H, L, L, Z,   H, L, Z,            H, 32'h10,        L, Z,            Z));
        vecs.push_back(mk(L, L, L, Z,   H, H, 32'h100,      L, Z,             L, Z,            Z));
        vecs.push_back(mk(L, H, L, BAD, H, L, Z,            L, Z,             L, Z,            Z));
        vecs.push_back(mk(H, L, L, Z,   H, L, Z,            H, 32'h100,       L, Z,            Z));
        vecs.push_back(mk(L, H, H, D4,  H, L, Z,            L, Z,             L, Z,            Z));
        vecs.push_back(mk(L, L, L, Z,   H, L, Z,            L, Z,             H, 32'h100,      D4));
        vecs.push_back(mk(H, L, L, Z,   H, H, 32'h200,      H, 32'h104,       L, Z,            Z));
        vecs.push_back(mk(L, L, L, Z,   H, L, Z,            L, Z,             L, Z,            Z));
        vecs.push_back(mk(L, H, L, BAD, H, L, Z,            L, Z,             L, Z,            Z));
        vecs.push_back(mk(H, L, L, Z,   H, L, Z,            H, 32'h200,       L, Z,            Z));
        vecs.push_back(mk(L, H, H, D5,  H, L, Z,            L, Z,             L, Z,            Z));
        vecs.push_back(mk(L, L, L, Z,   H, L, Z,            L, Z,             H, 32'h200,      D5));
        vecs.push_back(mk(H, L, L, Z,   H, L, Z,            H, 32'h204,       L, Z,            Z));
        vecs.push_back(mk(L, H, L, BAD, H, H, 32'h300,      L, Z,             L, Z,            Z));
        vecs.push_back(mk(L, L, L, Z,   H, H, 32'h400,      H, 32'h300,       L, Z,            Z));
        vecs.push_back(mk(H, L, L, Z,   H, L, Z,            H, 32'h400,       L, Z,            Z));
        vecs.push_back(mk(L, H, H, D6,  H, L, Z,            L, Z,             L, Z,            Z));
        vecs.push_back(mk(L, L, L, Z,   H, H, 32'h500,      L, Z,             H, 32'h400,      D6));
        vecs.push_back(mk(L, L, L, Z,   H, L, Z,            H, 32'h500,       L, Z,            Z));

        foreach (vecs[i]) apply_vec(vecs[i], i);

`ifdef FETCH_ALIGN_CHECK_EN
        cyc(L, L, Z, H, H, 32'h102);
        chk1("err entry mis", mis, 1'b0);
        cyc(H, L, Z, H, L, Z);
        chk1("err req", req, 1'b0);
        chk1("err mis", mis, 1'b1);
        chk1("err valid", valid, 1'b0);
        repeat (2) begin
            cyc(H, L, Z, H, L, Z);
            chk1("err hold req", req, 1'b0);
            chk1("err hold mis", mis, 1'b1);
        end
        cyc(L, L, Z, H, H, 32'h200);
        chk1("err exit mis", mis, 1'b1);
        cyc(H, L, Z, H, L, Z);
        chk1("resume mis", mis, 1'b0);
        chk1("resume req", req, 1'b1);
        chk("resume addr", addr, 32'h200);
        sbq.push_back('{32'h200, D7});
        cyc(L, H, D7, H, L, Z);
        cyc(L, L, Z, H, L, Z);
        chk1("resume valid", valid, 1'b1);
        cyc(H, L, Z, H, H, 32'h306);
        chk("flush mis addr", addr, 32'h204);
        cyc(L, L, Z, H, L, Z);
        chk1("flush mis req", req, 1'b0);
        chk1("flush mis flag", mis, 1'b0);
        cyc(L, H, BAD, H, L, Z);
        chk1("flush mis drop", mis, 1'b0);
        cyc(L, L, Z, H, L, Z);
        chk1("post flush mis", mis, 1'b1);
        chk1("post flush req", req, 1'b0);
        cyc(L, L, Z, H, H, 32'h300);
        cyc(L, L, Z, H, L, Z);
        chk1("realign mis", mis, 1'b0);
        chk("realign addr", addr, 32'h300);
`else
        cyc(L, L, Z, H, H, 32'h602);
        chk("lsb old addr", addr, 32'h500);
        cyc(H, L, Z, H, L, Z);
        chk("lsb forced addr", addr, 32'h600);
        chk1("lsb mis", mis, 1'b0);
        sbq.push_back('{32'h600, D7});
        cyc(L, H, D7, H, L, Z);
        cyc(L, L, Z, H, L, Z);
        chk1("lsb valid", valid, 1'b1);
`endif

        // Reset while an instruction sits in the output stage.
        cyc(H, L, Z, L, L, Z);
        chk1("mid req", req, 1'b1);
        cyc(L, H, D0, L, L, Z);
        cyc(L, L, Z, L, L, Z);
        chk1("mid valid", valid, 1'b1);
        rst_l = 1'b0;
        cyc(L, L, Z, L, L, Z);
        chk1("mid rst req", req, 1'b0);
        chk1("mid rst valid", valid, 1'b0);
        chk("mid rst addr", addr, 32'h0);
        chk("mid rst pc", pc, 32'h0);
        chk("mid rst instr", instr, NOP);
        rst_l = 1'b1;
        cyc(L, L, Z, H, L, Z);
        chk1("post rst req", req, 1'b1);
        chk("post rst addr", addr, 32'h0);

        cyc2(H, L, Z, H);
        chk1("wrap req0", req2, 1'b1);
        chk("wrap addr0", addr2, 32'hFFFF_FFFC);
        cyc2(L, H, D1, H);
        chk1("wrap wait req", req2, 1'b0);
        cyc2(L, L, Z, H);
        chk1("wrap valid", valid2, 1'b1);
        chk("wrap pc", pc2, 32'hFFFF_FFFC);
        chk("wrap instr", instr2, D1);
        cyc2(H, L, Z, H);
        chk1("wrap req1", req2, 1'b1);
        chk("wrap addr1", addr2, 32'h0);
        chk1("wrap mis", mis2, 1'b0);
        chk("wrap opcode", {25'b0, opcode2}, {25'b0, D1[6:0]});

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_left: got %0d pending deliveries, expected 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the producer side of the opcode interface consumed by `control`. It owns the program counter and issues single-outstanding reads to instruction memory. It holds each returned instruction in a registered output stage and presents it, with its opcode field and PC, to decode under a valid/ready handshake. Taken branch/jump redirects from execute flush in-flight work and restart fetch at the new target.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `NOP_INSTR`, default `32'h0000_0013`: `instr_w_o` value while empty or after reset (`addi x0,x0,0`).
- `clk_w_i` in 1: clock. One clock; all state updates on its rising edge.
- `rst_w_i_l` in 1: reset, synchronous and active-low.
- `imem_req_w_o_h` out 1: read request.
- `imem_addr_w_o` out 32: read address, stable while `imem_req_w_o_h` is high and not granted.
- `imem_gnt_w_i_h` in 1: request accepted this cycle.
- `imem_rvalid_w_i_h` in 1: read data valid. In order, at least 1 cycle after the grant.
- `imem_rdata_w_i` in 32: read data.
- `redirect_w_i_h` in 1: taken branch/jal/jalr.
- `redirect_pc_w_i` in 32: redirect target.
- `instr_valid_w_o_h` out 1: instruction available to decode.
- `instr_ready_w_i_h` in 1: decode accepts.
- `instr_w_o` out 32: instruction.
- `opcode_w_o` out 7: `instr_w_o[6:0]`, wired to `control.opcode_w_i`.
- `pc_w_o` out 32: address of `instr_w_o`.
- `misalign_w_o_h` out 1: misaligned redirect target flag (see Configuration).

## Operation
- Internal `fetch_pc` register: address of the next fetch.
- FSM states: REQ, WAIT, HOLD, FLUSH (plus ERR with the macro).
- REQ: `imem_req_w_o_h`=1, `imem_addr_w_o`=`fetch_pc`.
  - Grant → WAIT.
  - No grant → stay in REQ.
- WAIT: on `imem_rvalid_w_i_h`, register `imem_rdata_w_i` into `instr_w_o` and `fetch_pc` into `pc_w_o`.
  - Set `instr_valid_w_o_h`, `fetch_pc` += 4 (mod 2^32, wraps from `32'hFFFF_FFFC` to 0), → HOLD.
- HOLD: `instr_valid_w_o_h`=1, outputs stable.
  - On valid&ready: clear valid, → REQ.
- FLUSH: one response is outstanding and must be discarded.
  - On `imem_rvalid_w_i_h`, drop the data, → REQ.
- Redirect has priority in every state. `fetch_pc` ← `redirect_pc_w_i`, `instr_valid_w_o_h` cleared next cycle. Next state by current state:
  - REQ without grant → REQ, new address.
  - REQ with grant in the same cycle → FLUSH.
  - WAIT without rvalid → FLUSH.
  - WAIT with rvalid in the same cycle → REQ, data discarded.
  - HOLD → REQ. If ready was also high, the handshake counts as completed.
  - FLUSH without rvalid → FLUSH, with the newest target kept.
  - FLUSH with rvalid → REQ.
- At most one read is ever outstanding. No request is issued in WAIT or FLUSH.
- `opcode_w_o` is purely combinational from the `instr_w_o` register.

## Timing
- Reset values:
  - state REQ, `fetch_pc`=`RESET_PC`.
  - `imem_req_w_o_h`=0 during reset; `imem_addr_w_o`=`RESET_PC`.
  - `instr_valid_w_o_h`=0, `instr_w_o`=`NOP_INSTR`, `opcode_w_o`=`7'h13`, `pc_w_o`=`RESET_PC`, `misalign_w_o_h`=0.
- First request is asserted in the first cycle with `rst_w_i_l` high.
- Grant in cycle t, rvalid in t+1 → `instr_valid_w_o_h` high in t+2.
- Ready in t+2 → next request in t+3. Peak throughput is one instruction per 3 cycles.
- Redirect in cycle t → new `imem_addr_w_o` visible in t+1, unless flushing.
- Reset asserted mid-operation returns everything to reset values at the next edge. Instruction memory shares the same reset, so no stale response follows.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc_w_i[1:0]`≠0 enters ERR after any pending flush completes. ERR issues no requests and keeps valid low.
  - `misalign_w_o_h`=1 while in ERR.
  - Only an aligned redirect or reset exits ERR: aligned redirect → REQ, and `misalign_w_o_h` clears the next cycle.
- Undefined:
  - `redirect_pc_w_i[1:0]` is forced to 00.
  - `misalign_w_o_h` is tied 0.
  - No ERR state.

## Structure
- Shared package `cpu_pkg`, holding:
  - fetch state enum;
  - `OPCODE_W`=7;
  - `NOP_INSTR` constant;
  - RV32I opcode constants (JAL `7'h6F`, JALR `7'h67`, BRANCH `7'h63`) shared with `control`.
- Single module, no sub-modules. The output stage is a simple register and does not justify its own block.

## Test plan
- Reset release, zero-wait memory (grant on request, rvalid next cycle), ready tied high → addresses 0, 4, 8, one every 3 cycles; first valid instruction in cycle 3 with `pc_w_o`=0.
- Ready held low for 5 cycles in HOLD → `instr_w_o`/`pc_w_o` stable, no new request; ready rises → request for `pc_w_o`+4 the next cycle.
- Redirect to `32'h100` in WAIT → rvalid data is discarded, not presented to decode; next request address `32'h100`.
- Redirect in REQ together with grant → FLUSH, one response dropped, then request at the target.
- `RESET_PC`=`32'hFFFF_FFFC` → second fetch address 0 (wrap).
- With `FETCH_ALIGN_CHECK_EN`, redirect to `32'h102` → `misalign_w_o_h`=1, no requests. Then redirect to `32'h200` → flag clears and fetch resumes at `32'h200`.
